stream_burst_ctrl: RTL

//  Parametrised output-stream sequencer between the core array and the AXI-Stream master (M_AXIS).

---
 rtl/stream_burst_ctrl.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/stream_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : stream_burst_ctrl
// Desc     : Trigger-queued burst sequencer feeding an AXI-Stream master port.
// Revision : 1.0
// ============================================================================

module stream_burst_ctrl #(
  parameter  int BEATS  = 32,
  parameter  int SETTLE = 1,
  parameter  int PEND_W = 2,
  localparam int IDX_W  = $clog2(BEATS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              trig_i,
  input  logic              flush_i,
  input  logic              dst_ready_i,
  output logic              dst_valid_o,
  output logic              dst_last_o,
  output logic              stream_v_o,
  output logic [IDX_W-1:0]  stream_i_o,
  output logic              busy_o,
  output logic [PEND_W-1:0] pend_o,
  output logic              overflow_o
);

  localparam int               CNT_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((SETTLE > 0) ? SETTLE - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BEATS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic [IDX_W-1:0]  idx_q,   idx_d;
  logic [PEND_W-1:0] pend_q,  pend_d;
  logic              valid_q, valid_d;
  logic              last_q,  last_d;
  logic              ovf_q,   ovf_d;

  logic              beat_w;
  logic              done_w;

  assign beat_w = (state_q == S_RUN) && dst_ready_i;
  assign done_w = beat_w && (idx_q == IDX_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    pend_d  = pend_q;
    valid_d = valid_q;
    last_d  = last_q;
    ovf_d   = 1'b0;

    // A trigger coinciding with burst completion is a net no-op on the queue.
    if (trig_i && !done_w) begin
      if (&pend_q) begin
        ovf_d = 1'b1;
      end else begin
        pend_d = pend_q + 1'b1;
      end
    end else if (!trig_i && done_w && (pend_q != '0)) begin
      pend_d = pend_q - 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (pend_q != '0) begin
          if (SETTLE > 0) begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end else if (dst_ready_i) begin
            state_d = S_RUN;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (dst_ready_i) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (beat_w) begin
          if (done_w) begin
            idx_d = '0;
            if (pend_d == '0) begin
              state_d = S_IDLE;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Valid/last must stay stable while the sink stalls.
    if (dst_ready_i) begin
      valid_d = beat_w;
      last_d  = done_w;
    end

    if (flush_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      idx_d   = '0;
      pend_d  = '0;
      valid_d = 1'b0;
      last_d  = 1'b0;
      ovf_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      pend_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      ovf_q   <= ovf_d;
    end
  end

  assign stream_v_o  = beat_w;
  assign stream_i_o  = idx_q;
  assign dst_valid_o = valid_q;
  assign dst_last_o  = last_q;
  assign overflow_o  = ovf_q;
  assign pend_o      = pend_q;
  assign busy_o      = (state_q != S_IDLE) || (pend_q != '0);

endmodule

`default_nettype wire
